// File: rtl/watchdog_multi_pkg.sv
// Shared types and default parameters for the multi-channel watchdog.
package watchdog_multi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    EXPIRED = 2'd2
  } wdg_state_t;

  localparam int unsigned DEFAULT_NUM_CHANNELS  = 4;
  localparam int unsigned DEFAULT_COUNTER_WIDTH = 16;

endpackage

// File: rtl/watchdog_multi_if.sv
// Control/status bundle between a watchdog controller (master) and the watchdog (slave).
interface watchdog_multi_if
  import watchdog_multi_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS  = DEFAULT_NUM_CHANNELS,
  parameter int unsigned COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
);

  logic [NUM_CHANNELS-1:0]               arm;
  logic [NUM_CHANNELS-1:0]               disarm;
  logic [NUM_CHANNELS-1:0]               kick;
  logic [NUM_CHANNELS-1:0]               auto_reload;
  logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] limit;
  logic [NUM_CHANNELS-1:0]               clear_timeout;
  logic [NUM_CHANNELS-1:0]               timeout_vector;
  logic                                  timeout;
  logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] counter;
  logic [NUM_CHANNELS-1:0]               active;

  modport master (
    output arm, disarm, kick, auto_reload, limit, clear_timeout,
    input  timeout_vector, timeout, counter, active
  );

  modport slave (
    input  arm, disarm, kick, auto_reload, limit, clear_timeout,
    output timeout_vector, timeout, counter, active
  );

endinterface

// File: rtl/watchdog_channel.sv
// One watchdog channel: IDLE/RUNNING/EXPIRED FSM, saturating counter and sticky timeout flag.
module watchdog_channel
  import watchdog_multi_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     disarm,
  input  logic                     kick,
  input  logic                     auto_reload,
  input  logic [COUNTER_WIDTH-1:0] limit,
  input  logic                     clear_timeout,
  output logic                     timeout_flag,
  output logic [COUNTER_WIDTH-1:0] counter,
  output logic                     active
);

  wdg_state_t               state;
  logic [COUNTER_WIDTH-1:0] latched_limit;
  logic                     reload_mode;
  logic                     expire;

  // Expiry only fires when no higher-priority action claims this edge.
  always_comb begin
    expire = 1'b0;
    if (!disarm && !arm && !kick && (state == RUNNING) && (counter == latched_limit)) begin
      expire = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      counter       <= '0;
      latched_limit <= '0;
      reload_mode   <= 1'b0;
      active        <= 1'b0;
      timeout_flag  <= 1'b0;
    end else begin
      // Set beats clear on the same edge.
      if (expire) begin
        timeout_flag <= 1'b1;
      end else if (clear_timeout) begin
        timeout_flag <= 1'b0;
      end

      if (disarm) begin
        state   <= IDLE;
        counter <= '0;
        active  <= 1'b0;
      end else if (arm) begin
        state         <= RUNNING;
        counter       <= '0;
        latched_limit <= limit;
        reload_mode   <= auto_reload;
        active        <= 1'b1;
      end else if (state == RUNNING) begin
        if (kick) begin
          counter <= '0;
        end else if (counter == latched_limit) begin
          if (reload_mode) begin
            counter <= '0;
          end else begin
            state  <= EXPIRED;
            active <= 1'b0;
          end
        end else begin
          counter <= counter + COUNTER_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/watchdog_multi.sv
// Multi-channel watchdog: replicates watchdog_channel and packs per-channel status onto the bus.
module watchdog_multi
  import watchdog_multi_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS  = DEFAULT_NUM_CHANNELS,
  parameter int unsigned COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  watchdog_multi_if.slave  bus
);

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    watchdog_channel #(
      .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_channel (
      .clock         (clock),
      .reset         (reset),
      .arm           (bus.arm[i]),
      .disarm        (bus.disarm[i]),
      .kick          (bus.kick[i]),
      .auto_reload   (bus.auto_reload[i]),
      .limit         (bus.limit[i*COUNTER_WIDTH +: COUNTER_WIDTH]),
      .clear_timeout (bus.clear_timeout[i]),
      .timeout_flag  (bus.timeout_vector[i]),
      .counter       (bus.counter[i*COUNTER_WIDTH +: COUNTER_WIDTH]),
      .active        (bus.active[i])
    );
  end

  // Summary flag is a plain OR of registered per-channel flags.
  assign bus.timeout = |bus.timeout_vector;

endmodule

// File: tb/tb_watchdog_multi.sv
// Directed bench for watchdog_multi with an elapsed-time reference model checked every cycle.
module tb_watchdog_multi;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;

  watchdog_multi_if #(.NUM_CHANNELS(N), .COUNTER_WIDTH(W)) bus ();

  watchdog_multi #(.NUM_CHANNELS(N), .COUNTER_WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: per channel, edges elapsed since last arm/kick, plus mode and limit.
  bit     m_run  [N];
  bit     m_ar   [N];
  bit     m_flag [N];
  longint m_lim  [N];
  longint m_n    [N];

  function automatic longint exp_counter(int i);
    if (m_ar[i]) return m_n[i] % (m_lim[i] + 1);
    return (m_n[i] > m_lim[i]) ? m_lim[i] : m_n[i];
  endfunction

  function automatic bit exp_active(int i);
    return m_run[i] && (m_ar[i] || m_n[i] <= m_lim[i]);
  endfunction

  longint nn, ll;
  bit     rr, aa, ff, hit;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_run[i] <= 1'b0; m_ar[i] <= 1'b0; m_flag[i] <= 1'b0;
        m_lim[i] <= 0;    m_n[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        nn = m_n[i]; ll = m_lim[i]; rr = m_run[i]; aa = m_ar[i]; hit = 1'b0;
        if (bus.disarm[i]) begin
          rr = 1'b0; nn = 0;
        end else if (bus.arm[i]) begin
          rr = 1'b1; nn = 0; ll = longint'(bus.limit[i*W +: W]); aa = bus.auto_reload[i];
        end else if (exp_active(i)) begin
          if (bus.kick[i]) nn = 0;
          else begin
            nn = nn + 1;
            hit = aa ? ((nn % (ll + 1)) == 0) : (nn == ll + 1);
          end
        end
        ff = hit ? 1'b1 : (bus.clear_timeout[i] ? 1'b0 : m_flag[i]);
        m_n[i] <= nn; m_lim[i] <= ll; m_run[i] <= rr; m_ar[i] <= aa; m_flag[i] <= ff;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    bit any;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("model_counter%0d", i), longint'(bus.counter[i*W +: W]), exp_counter(i));
      chk($sformatf("model_active%0d", i), longint'(bus.active[i]), longint'(exp_active(i)));
      chk($sformatf("model_flag%0d", i), longint'(bus.timeout_vector[i]), longint'(m_flag[i]));
      any = any | m_flag[i];
    end
    chk("model_timeout", longint'(bus.timeout), longint'(any));
  end

  function automatic longint ctr(int ch);
    return longint'(bus.counter[ch*W +: W]);
  endfunction

  // One clock: pulses driven before this call act on the coming edge, then drop.
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
      bus.arm = '0; bus.disarm = '0; bus.kick = '0; bus.clear_timeout = '0;
    end
  endtask

  task automatic arm_ch(int ch, int unsigned lim, bit ar);
    bus.arm[ch] = 1'b1;
    bus.auto_reload[ch] = ar;
    bus.limit[ch*W +: W] = W'(lim);
  endtask

  initial begin
    bus.arm = '0; bus.disarm = '0; bus.kick = '0; bus.clear_timeout = '0;
    bus.auto_reload = '0; bus.limit = '0;
    repeat (3) @(negedge clock);
    chk("reset_tv", longint'(bus.timeout_vector), 0);
    chk("reset_timeout", longint'(bus.timeout), 0);
    chk("reset_counter", longint'(bus.counter), 0);
    chk("reset_active", longint'(bus.active), 0);
    reset = 1'b0;
    tick();

    // One-shot, ch0, L=5
    arm_ch(0, 5, 1'b0); tick();
    chk("os_ctr0", ctr(0), 0);
    chk("os_active", longint'(bus.active[0]), 1);
    tick(5);
    chk("os_ctr5", ctr(0), 5);
    chk("os_noflag", longint'(bus.timeout_vector), 0);
    tick();
    chk("os_tv", longint'(bus.timeout_vector), 4'b0001);
    chk("os_timeout", longint'(bus.timeout), 1);
    chk("os_hold", ctr(0), 5);
    chk("os_inactive", longint'(bus.active[0]), 0);
    bus.kick[0] = 1'b1; tick(2);
    chk("os_kick_ignored", ctr(0), 5);
    bus.clear_timeout[0] = 1'b1; tick();
    chk("os_cleared", longint'(bus.timeout_vector[0]), 0);

    // Kick in the expiry cycle, ch1, L=3
    arm_ch(1, 3, 1'b0); tick(4);
    chk("kick_pre", ctr(1), 3);
    bus.kick[1] = 1'b1; tick();
    chk("kick_zero", ctr(1), 0);
    chk("kick_noflag", longint'(bus.timeout_vector[1]), 0);
    tick(3);
    chk("kick_noflag3", longint'(bus.timeout_vector[1]), 0);
    tick();
    chk("kick_flag4", longint'(bus.timeout_vector[1]), 1);

    // Auto-reload, ch2, L=2
    arm_ch(2, 2, 1'b1); tick();
    tick(2);
    chk("ar_ctr2", ctr(2), 2);
    tick();
    chk("ar_wrap", ctr(2), 0);
    chk("ar_flag3", longint'(bus.timeout_vector[2]), 1);
    tick();
    bus.clear_timeout[2] = 1'b1; tick();
    chk("ar_clear5", longint'(bus.timeout_vector[2]), 0);
    chk("ar_running", longint'(bus.active[2]), 1);
    tick();
    chk("ar_reset6", longint'(bus.timeout_vector[2]), 1);
    bus.disarm[2] = 1'b1; bus.clear_timeout[2] = 1'b1; tick();

    // Priority on ch3
    arm_ch(3, 10, 1'b0); tick(3);
    bus.disarm[3] = 1'b1; bus.arm[3] = 1'b1; bus.kick[3] = 1'b1; tick();
    chk("prio_idle", longint'(bus.active[3]), 0);
    chk("prio_ctr", ctr(3), 0);
    arm_ch(3, 1, 1'b0); tick(2);
    bus.clear_timeout[3] = 1'b1; tick();
    chk("prio_set_wins", longint'(bus.timeout_vector[3]), 1);
    arm_ch(3, 4, 1'b0); tick();
    chk("rearm_keeps_flag", longint'(bus.timeout_vector[3]), 1);
    bus.disarm = '1; bus.clear_timeout = '1; tick();
    chk("all_clear", longint'(bus.timeout), 0);

    // Boundaries: L=0 on ch0, L=FFFF on ch1
    arm_ch(0, 0, 1'b0); tick();
    chk("l0_noflag", longint'(bus.timeout_vector[0]), 0);
    tick();
    chk("l0_flag", longint'(bus.timeout_vector[0]), 1);
    arm_ch(1, 16'hFFFF, 1'b0); tick();
    tick(65535);
    chk("max_ctr", ctr(1), 16'hFFFF);
    chk("max_noflag", longint'(bus.timeout_vector[1]), 0);
    tick();
    chk("max_flag", longint'(bus.timeout_vector[1]), 1);
    tick();
    chk("max_nowrap", ctr(1), 16'hFFFF);

    // Async reset mid-count
    arm_ch(0, 10, 1'b0); tick(4);
    chk("rst_pre_ctr", ctr(0), 3);
    chk("rst_pre_flag", longint'(bus.timeout_vector[1]), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_counter", longint'(bus.counter), 0);
    chk("arst_tv", longint'(bus.timeout_vector), 0);
    chk("arst_timeout", longint'(bus.timeout), 0);
    chk("arst_active", longint'(bus.active), 0);
    @(negedge clock);
    reset = 1'b0;
    arm_ch(2, 1, 1'b0); tick(3);
    chk("post_rst_flag", longint'(bus.timeout_vector), 4'b0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/watchdog_multi.md
# watchdog_multi

Parametrised multi-channel watchdog timer, the successor to the single-counter watchdog in the ALU testbench top. Each of `NUM_CHANNELS` independent channels counts clock cycles against its own run-time limit, is restarted by a per-channel kick, and raises a sticky timeout flag. Channels run in either one-shot or auto-reload mode. Per-channel counters are exported so the watchdog interface can monitor progress, and `timeout` is the OR of all channel flags.

## Interface
- `NUM_CHANNELS`, 4: number of independent channels, ≥1.
- `COUNTER_WIDTH`, 16: width of each counter and limit.

- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `arm` in NUM_CHANNELS: start or restart channel i and latch its limit.
- `disarm` in NUM_CHANNELS: stop channel i and return it to idle.
- `kick` in NUM_CHANNELS: service channel i and zero its counter.
- `auto_reload` in NUM_CHANNELS: mode, sampled with `arm`. 1 = reload after expiry, 0 = one-shot.
- `limit` in NUM_CHANNELS*COUNTER_WIDTH: channel i occupies bits [i*W +: W].
- `clear_timeout` in NUM_CHANNELS: clear the sticky flag of channel i.
- `timeout_vector` out NUM_CHANNELS: sticky per-channel timeout flags.
- `timeout` out 1: OR of `timeout_vector`.
- `counter` out NUM_CHANNELS*COUNTER_WIDTH: live counter of each channel.
- `active` out NUM_CHANNELS: 1 when channel i is RUNNING.

## Operation
- Per-channel FSM states are IDLE, RUNNING and EXPIRED.
- The following actions apply at a rising edge, in priority order. Only the highest-priority applicable action takes effect.
  1. `disarm`: go to IDLE, counter ← 0. The sticky flag is untouched.
  2. `arm`, from any state:
     - latch `limit` and `auto_reload`;
     - counter ← 0;
     - go to RUNNING.
  3. RUNNING and `kick`: counter ← 0. A kick in the expiry cycle prevents the timeout.
  4. RUNNING and counter == latched limit: expiry. The sticky flag is set, then:
     - auto-reload: counter ← 0, stay RUNNING;
     - one-shot: counter holds at the limit, go to EXPIRED.
  5. RUNNING: counter ← counter + 1.
- Because the counter never exceeds the latched limit, it never wraps, including when limit = 2^W−1.
- In IDLE and EXPIRED, `kick` is ignored and the counter holds.
- Sticky flag:
  - it is set on expiry and cleared only by `clear_timeout` or `reset`;
  - if set and clear occur in the same cycle, set wins;
  - re-arming does not clear it.
- Limit = 0 is legal: expiry occurs on the first edge after arm.
- Channels are fully independent. Simultaneous events on different channels do not interact.

## Timing
- All outputs are registered except `timeout`, which is the combinational OR of registered flags.
- Reset values: all counters 0, all channels IDLE, `active` = 0, `timeout_vector` = 0, `timeout` = 0. Reset takes effect immediately, mid-count included.
- Arm at edge E0 with limit L and no kicks gives:
  - `counter` = k after edge E0+k;
  - the flag rises after edge E0+L+1.
  - Timeout latency from arm is therefore L+1 cycles.
- A kick at edge Ek sets `counter` = 0 after Ek. The next expiry is L+1 edges later.
- Auto-reload period is L+1 cycles. The flag stays high and does not pulse.
- `active` falls on the edge that enters EXPIRED or IDLE.

## Structure
- `watchdog_multi_pkg` holds:
  - the state enum typedef (`IDLE`, `RUNNING`, `EXPIRED`);
  - the default parameter constants.
- Sub-module `watchdog_channel` (parameter `COUNTER_WIDTH`) contains one FSM, its counter and its sticky flag.
- The top instantiates `watchdog_channel` NUM_CHANNELS times in a generate loop, packs the buses and ORs the flags.

## Test plan
- **One-shot expiry:** arm ch0, L=5, one-shot, no kicks → counter reads 0..5; `timeout_vector`=4'b0001 and `timeout`=1 after edge 6; counter holds at 5; `active[0]`=0.
- **Kick in expiry cycle:** arm ch1, L=3, kick at the edge where counter==3 → counter=0, no flag; without further kicks the flag sets 4 edges later.
- **Auto-reload:** arm ch2, L=2, auto_reload=1 → counter sequence 0,1,2,0,1,2…; flag set after edge 3 and stays high; `clear_timeout` at edge 5 clears it; the flag re-sets at edge 6.
- **Priority:** same edge disarm+arm+kick on ch3 → IDLE, counter 0. Same edge clear_timeout with expiry → flag stays 1.
- **Boundary limits:** L=0 arm → flag after 1 edge. L=16'hFFFF, W=16 → counter reaches FFFF, no wrap to 0 in one-shot mode.
- **Async reset mid-count:** ch0 counter=3 with flags set on ch1 → assert `reset` between edges; all outputs 0 immediately, before the next edge.
